// File: rtl/dsa_debug_pkg.sv
// Shared types and constants for the DSA single-step / breakpoint controller.
// Optional feature macro: DSA_STEP_COORD_BREAK_EN (coordinate breakpoint, opcode 7).
package dsa_debug_pkg;

  localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

  typedef enum logic [2:0] {
    FREE_RUN = 3'd0,
    HALTED   = 3'd1,
    STEPPING = 3'd2,
    RUN_BP   = 3'd3,
    ACK      = 3'd4
  } ctrl_state_e;

  typedef enum logic [2:0] {
    CMD_NOP          = 3'd0,
    CMD_ENABLE_STEP  = 3'd1,
    CMD_DISABLE_STEP = 3'd2,
    CMD_STEP_ONE     = 3'd3,
    CMD_STEP_N       = 3'd4,
    CMD_RUN_TO_BREAK = 3'd5,
    CMD_HALT         = 3'd6,
    CMD_SET_BP_X     = 3'd7
  } cmd_op_e;

  typedef struct packed {
    cmd_op_e     op;
    logic [15:0] arg;
  } cmd_req_t;

endpackage

// File: rtl/dsa_break_match.sv
// Breakpoint comparator: observed FSM state vs latched breakpoint state, plus
// an output-coordinate match when DSA_STEP_COORD_BREAK_EN is defined.
module dsa_break_match import dsa_debug_pkg::*; #(
  parameter int STATE_WIDTH = 4
) (
  input  logic [STATE_WIDTH-1:0] obs,
  input  logic [STATE_WIDTH-1:0] bp_state,
`ifdef DSA_STEP_COORD_BREAK_EN
  input  logic                   coord_en,
  input  logic [15:0]            cur_x,
  input  logic [15:0]            cur_y,
  input  logic [15:0]            bp_x,
  input  logic [15:0]            bp_y,
`endif
  output logic                   hit
);

`ifdef DSA_STEP_COORD_BREAK_EN
  assign hit = (obs == bp_state) || (coord_en && ({cur_y, cur_x} == {bp_y, bp_x}));
`else
  assign hit = (obs == bp_state);
`endif

endmodule

// File: rtl/dsa_step_controller.sv
// Host-driven single-step / run-to-breakpoint gate for the DSA state machines.
// Optional feature macro: DSA_STEP_COORD_BREAK_EN (coordinate breakpoint, opcode 7).
module dsa_step_controller import dsa_debug_pkg::*; #(
  parameter int STATE_WIDTH    = 4,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [2:0]             cmd_op,
  input  logic [15:0]            cmd_arg,
  input  logic [STATE_WIDTH-1:0] fsm_state_seq,
  input  logic [STATE_WIDTH-1:0] fsm_state_simd,
  input  logic                   mode_simd,
  input  logic [15:0]            current_x,
  input  logic [15:0]            current_y,
  output logic                   dsa_advance,
  output logic                   capture_enable,
  output logic                   step_ack,
  output logic [CNT_WIDTH-1:0]   step_count,
  output logic                   busy,
  output logic                   timeout_flag
);

  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  ctrl_state_e            ctrl_q, ctrl_d;
  logic [STATE_WIDTH-1:0] obs, prev_state_q, prev_state_d, bp_state_q, bp_state_d;
  logic [15:0]            remaining_q, remaining_d;
  logic [CNT_WIDTH-1:0]   step_count_q, step_count_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;
  logic                   timeout_flag_q, timeout_flag_d;
  cmd_req_t               req;
  logic                   cmd_acc, halt_acc, moved, tmo_hit, hit;

  assign obs      = mode_simd ? fsm_state_simd : fsm_state_seq;
  assign req.op   = cmd_op_e'(cmd_op);
  assign req.arg  = cmd_arg;
  // HALT is always accepted so the host can abort a running step.
  assign cmd_ready = !busy || (req.op == CMD_HALT);
  assign cmd_acc  = cmd_valid && cmd_ready;
  assign halt_acc = cmd_acc && (req.op == CMD_HALT);
  assign moved    = (obs != prev_state_q);
  assign tmo_hit  = (tmo_q == TMO_LAST);

  assign step_count   = step_count_q;
  assign timeout_flag = timeout_flag_q;

`ifdef DSA_STEP_COORD_BREAK_EN
  logic [15:0] bp_x_q, bp_x_d, bp_y_q, bp_y_d;
  logic        coord_en_q, coord_en_d;

  dsa_break_match #(.STATE_WIDTH(STATE_WIDTH)) u_match (
    .obs(obs), .bp_state(bp_state_q), .coord_en(coord_en_q),
    .cur_x(current_x), .cur_y(current_y), .bp_x(bp_x_q), .bp_y(bp_y_q), .hit(hit)
  );

  // Coordinate breakpoint registers: bp_x by SET_BP_X, bp_y by RUN_TO_BREAK with arg[15].
  always_comb begin
    bp_x_d     = bp_x_q;
    bp_y_d     = bp_y_q;
    coord_en_d = coord_en_q;
    if (cmd_acc && !busy && req.op == CMD_SET_BP_X) bp_x_d = req.arg;
    if (cmd_acc && ctrl_q == HALTED && req.op == CMD_RUN_TO_BREAK) begin
      coord_en_d = req.arg[15];
      if (req.arg[15]) bp_y_d = {1'b0, req.arg[14:0]};
    end
  end

  // Coordinate breakpoint flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bp_x_q     <= '0;
      bp_y_q     <= '0;
      coord_en_q <= 1'b0;
    end else begin
      bp_x_q     <= bp_x_d;
      bp_y_q     <= bp_y_d;
      coord_en_q <= coord_en_d;
    end
  end
`else
  logic unused_coord;
  assign unused_coord = ^{current_x, current_y};

  dsa_break_match #(.STATE_WIDTH(STATE_WIDTH)) u_match (
    .obs(obs), .bp_state(bp_state_q), .hit(hit)
  );
`endif

  // Controller state register.
  always_ff @(posedge clk) begin
    if (!rst_n) ctrl_q <= FREE_RUN;
    else        ctrl_q <= ctrl_d;
  end

  // Next-state: host commands, step completion, timeout and HALT abort.
  always_comb begin
    ctrl_d = ctrl_q;
    case (ctrl_q)
      FREE_RUN: if (cmd_acc && req.op == CMD_ENABLE_STEP) ctrl_d = HALTED;
      HALTED: if (cmd_acc) begin
        case (req.op)
          CMD_STEP_ONE:     ctrl_d = STEPPING;
          CMD_STEP_N:       if (req.arg != '0) ctrl_d = STEPPING;
          CMD_RUN_TO_BREAK: ctrl_d = RUN_BP;
          CMD_DISABLE_STEP: ctrl_d = FREE_RUN;
          default:          ;
        endcase
      end
      STEPPING: begin
        if (halt_acc)             ctrl_d = HALTED;
        else if (moved || tmo_hit) ctrl_d = ACK;
      end
      RUN_BP: begin
        if (halt_acc) ctrl_d = HALTED;
        else if (hit) ctrl_d = ACK;
      end
      ACK: ctrl_d = (halt_acc || remaining_q <= 16'd1) ? HALTED : STEPPING;
      default: ctrl_d = FREE_RUN;
    endcase
  end

  // Outputs: advance gate, capture, ack pulse and busy decoded from controller state.
  always_comb begin
    dsa_advance    = 1'b0;
    capture_enable = 1'b1;
    step_ack       = 1'b0;
    busy           = 1'b0;
    case (ctrl_q)
      FREE_RUN: begin dsa_advance = 1'b1; capture_enable = 1'b0; end
      // Gate closes in the cycle right after a transition, so only one lands.
      STEPPING: begin dsa_advance = !moved; busy = 1'b1; end
      RUN_BP:   begin dsa_advance = !hit;   busy = 1'b1; end
      ACK:      begin step_ack = 1'b1;      busy = 1'b1; end
      default:  ;
    endcase
  end

  // Datapath next values: remaining steps, step counter, timeout tracking, breakpoint.
  always_comb begin
    prev_state_d   = obs;
    bp_state_d     = bp_state_q;
    remaining_d    = remaining_q;
    step_count_d   = step_count_q;
    timeout_flag_d = timeout_flag_q;
    tmo_d          = '0;
    case (ctrl_q)
      FREE_RUN: if (cmd_acc && req.op == CMD_ENABLE_STEP) begin
        step_count_d   = '0;
        timeout_flag_d = 1'b0;
      end
      HALTED: if (cmd_acc) begin
        case (req.op)
          CMD_STEP_ONE:     remaining_d = 16'd1;
          CMD_STEP_N:       remaining_d = req.arg;
          CMD_RUN_TO_BREAK: bp_state_d  = STATE_WIDTH'(req.arg[3:0]);
          default:          ;
        endcase
      end
      STEPPING: begin
        if (halt_acc) remaining_d = '0;
        else if (!moved) begin
          tmo_d = tmo_q + 1'b1;
          if (tmo_hit) timeout_flag_d = 1'b1;
        end
      end
      RUN_BP: if (halt_acc) remaining_d = '0;
      ACK: begin
        if (step_count_q != '1) step_count_d = step_count_q + 1'b1;
        remaining_d = (halt_acc || remaining_q == '0) ? '0 : remaining_q - 16'd1;
      end
      default: ;
    endcase
  end

  // Datapath flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_state_q   <= '0;
      bp_state_q     <= '0;
      remaining_q    <= '0;
      step_count_q   <= '0;
      timeout_flag_q <= 1'b0;
      tmo_q          <= '0;
    end else begin
      prev_state_q   <= prev_state_d;
      bp_state_q     <= bp_state_d;
      remaining_q    <= remaining_d;
      step_count_q   <= step_count_d;
      timeout_flag_q <= timeout_flag_d;
      tmo_q          <= tmo_d;
    end
  end

endmodule

// File: tb/tb_dsa_step_controller.sv
// Directed + randomized bench for dsa_step_controller with a model DSA FSM.
module tb_dsa_step_controller;
  import dsa_debug_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, cmd_valid, cmd_ready, mode_simd;
  logic [2:0]  cmd_op;
  logic [15:0] cmd_arg, cur_x, cur_y;
  logic [3:0]  fsm_seq, fsm_simd, tb_obs;
  logic        dsa_advance, capture_enable, step_ack, busy, timeout_flag;
  logic [31:0] step_count;

  // model DSA FSM controls
  logic        ld, stall;
  logic [3:0]  ld_val;
  int          stall_mode;
  int unsigned n_ack, n_adv;
  int          total, bad;

  always #5 clk = ~clk;

  dsa_step_controller dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .fsm_state_seq(fsm_seq),
    .fsm_state_simd(fsm_simd), .mode_simd(mode_simd), .current_x(cur_x),
    .current_y(cur_y), .dsa_advance(dsa_advance), .capture_enable(capture_enable),
    .step_ack(step_ack), .step_count(step_count), .busy(busy),
    .timeout_flag(timeout_flag)
  );

  assign tb_obs = mode_simd ? fsm_simd : fsm_seq;

  // Model DSA: the selected FSM counts 0..7 whenever its state enable is high.
  always @(posedge clk) begin
    if (ld) begin
      fsm_seq  <= ld_val;
      fsm_simd <= ld_val;
    end else if (dsa_advance && !stall) begin
      if (mode_simd) fsm_simd <= (fsm_simd + 4'd1) & 4'd7;
      else           fsm_seq  <= (fsm_seq + 4'd1) & 4'd7;
    end
  end

  always @(negedge clk) begin
    case (stall_mode)
      0:       stall = 1'b0;
      1:       stall = 1'b1;
      default: stall = 1'($urandom_range(0, 1));
    endcase
  end

  // Event counters: ack pulses and advance-open cycles while in stepping mode.
  always @(posedge clk) begin
    if (step_ack) n_ack <= n_ack + 1;
    if (dsa_advance && capture_enable) n_adv <= n_adv + 1;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [15:0] arg);
    int k = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
    #1;
    while (!cmd_ready && k < 2000) begin
      @(negedge clk); #1; k++;
    end
    check("cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = 3'd0; cmd_arg = 16'd0;
  endtask

  task automatic load(input logic [3:0] v);
    ld = 1'b1; ld_val = v;
    tick();
    ld = 1'b0;
    tick();
  endtask

  task automatic wait_idle(input int bound);
    int k = 0;
    while (busy && k < bound) begin tick(); k++; end
    check("idle", 32'(busy), 32'd0);
  endtask

  initial begin
    int unsigned base_ack, base_adv;
    int          exp_cnt, exp_ack, acks, k, n;
    logic [3:0]  st, bp, exp_obs;

    total = 0; bad = 0; exp_cnt = 0;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_arg = 16'd0;
    mode_simd = 1'b0; cur_x = 16'd0; cur_y = 16'd0;
    ld = 1'b1; ld_val = 4'd0; stall_mode = 0;
    tick(); tick();

    // 1: reset values, then ENABLE_STEP
    check("rst_adv", 32'(dsa_advance), 32'd1);
    check("rst_cap", 32'(capture_enable), 32'd0);
    check("rst_cnt", step_count, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ack", 32'(step_ack), 32'd0);
    check("rst_tmo", 32'(timeout_flag), 32'd0);
    ld = 1'b0; rst_n = 1'b1;
    tick();
    send(CMD_ENABLE_STEP, 16'd0);
    check("en_adv", 32'(dsa_advance), 32'd0);
    check("en_cap", 32'(capture_enable), 32'd1);

    // 2: STEP_ONE, FSM 2 -> 3, exact cycle-by-cycle latency
    load(4'd2);
    base_ack = n_ack; base_adv = n_adv;
    send(CMD_STEP_ONE, 16'd0);
    check("s1_c1_adv", 32'(dsa_advance), 32'd1);
    check("s1_c1_busy", 32'(busy), 32'd1);
    tick();
    check("s1_c2_adv", 32'(dsa_advance), 32'd0);
    check("s1_c2_ack", 32'(step_ack), 32'd0);
    tick();
    check("s1_c3_ack", 32'(step_ack), 32'd1);
    tick();
    check("s1_c4_ack", 32'(step_ack), 32'd0);
    check("s1_busy", 32'(busy), 32'd0);
    exp_cnt += 1;
    check("s1_cnt", step_count, 32'(exp_cnt));
    check("s1_obs", 32'(tb_obs), 32'd3);
    check("s1_nadv", 32'(n_adv - base_adv), 32'd1);
    check("s1_nack", 32'(n_ack - base_ack), 32'd1);

    // 3: STEP_N 3 with FSM moving on every enabled cycle; busy rejects commands
    load(4'd1);
    base_ack = n_ack; base_adv = n_adv;
    send(CMD_STEP_N, 16'd3);
    cmd_valid = 1'b1; cmd_op = 3'(CMD_STEP_ONE); #1;
    check("busy_rdy", 32'(cmd_ready), 32'd0);
    cmd_op = 3'(CMD_HALT); #1;
    check("busy_halt_rdy", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b0; cmd_op = 3'd0;
    wait_idle(100);
    tick();
    exp_cnt += 3;
    check("sn_nack", 32'(n_ack - base_ack), 32'd3);
    check("sn_nadv", 32'(n_adv - base_adv), 32'd3);
    check("sn_cnt", step_count, 32'(exp_cnt));
    check("sn_obs", 32'(tb_obs), 32'd4);
    base_ack = n_ack;
    send(CMD_STEP_N, 16'd0);
    check("sn0_busy", 32'(busy), 32'd0);
    tick(); tick(); tick();
    check("sn0_nack", 32'(n_ack - base_ack), 32'd0);
    check("sn0_cap", 32'(capture_enable), 32'd1);

    // 5: RUN_TO_BREAK 5 from state 0
    load(4'd0);
    base_ack = n_ack; base_adv = n_adv;
    send(CMD_RUN_TO_BREAK, 16'd5);
    wait_idle(100);
    tick(); tick(); tick();
    exp_cnt += 1;
    check("bp_nack", 32'(n_ack - base_ack), 32'd1);
    check("bp_nadv", 32'(n_adv - base_adv), 32'd5);
    check("bp_obs", 32'(tb_obs), 32'd5);
    check("bp_cnt", step_count, 32'(exp_cnt));

    // 6: STEP_N 10, HALT right after the 2nd ack aborts the run
    load(4'd0);
    base_ack = n_ack;
    send(CMD_STEP_N, 16'd10);
    acks = 0; k = 0;
    while (acks < 2 && k < 200) begin
      tick();
      if (step_ack) acks++;
      k++;
    end
    check("halt_two_acks", 32'(acks), 32'd2);
    tick();
    send(CMD_HALT, 16'd0);
    check("halt_busy", 32'(busy), 32'd0);
    tick(); tick(); tick(); tick();
    exp_cnt += 2;
    check("halt_nack", 32'(n_ack - base_ack), 32'd2);
    check("halt_cnt", step_count, 32'(exp_cnt));
    check("halt_adv", 32'(dsa_advance), 32'd0);

    // randomized: mode, start state, STEP_N / RUN_TO_BREAK, random FSM stalls
    stall_mode = 2;
    for (int it = 0; it < 16; it++) begin
      mode_simd = 1'($urandom_range(0, 1));
      st = 4'($urandom_range(0, 7));
      load(st);
      tick();
      base_ack = n_ack;
      if ($urandom_range(0, 1) == 1) begin
        n = int'($urandom_range(1, 5));
        exp_ack = n;
        exp_obs = 4'((int'(st) + n) % 8);
        send(CMD_STEP_N, 16'(n));
      end else begin
        bp = 4'($urandom_range(0, 7));
        exp_ack = 1;
        exp_obs = bp;
        send(CMD_RUN_TO_BREAK, {12'd0, bp});
      end
      wait_idle(400);
      tick();
      exp_cnt += exp_ack;
      check("rnd_nack", 32'(n_ack - base_ack), 32'(exp_ack));
      check("rnd_obs", 32'(tb_obs), 32'(exp_obs));
      check("rnd_cnt", step_count, 32'(exp_cnt));
    end
    stall_mode = 0;
    mode_simd = 1'b0;
    tick(); tick();

    // 4: stalled FSM -> forced completion exactly TIMEOUT_CYCLES after entry
    stall_mode = 1;
    tick(); tick();
    base_ack = n_ack;
    send(CMD_STEP_ONE, 16'd0);
    repeat (1023) tick();
    check("tmo_pre_ack", 32'(step_ack), 32'd0);
    check("tmo_pre_flag", 32'(timeout_flag), 32'd0);
    tick();
    check("tmo_ack", 32'(step_ack), 32'd1);
    check("tmo_flag", 32'(timeout_flag), 32'd1);
    tick();
    exp_cnt += 1;
    check("tmo_busy", 32'(busy), 32'd0);
    check("tmo_cnt", step_count, 32'(exp_cnt));
    check("tmo_nack", 32'(n_ack - base_ack), 32'd1);
    stall_mode = 0;
    tick(); tick();

    // reset in the middle of a run
    send(CMD_STEP_N, 16'd10);
    tick(); tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    check("mid_rst_adv", 32'(dsa_advance), 32'd1);
    check("mid_rst_cap", 32'(capture_enable), 32'd0);
    check("mid_rst_ack", 32'(step_ack), 32'd0);
    check("mid_rst_cnt", step_count, 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_tmo", 32'(timeout_flag), 32'd0);
    rst_n = 1'b1;
    tick();

    // re-enable, one step, DISABLE then ENABLE clears the counter
    send(CMD_ENABLE_STEP, 16'd0);
    load(4'd6);
    send(CMD_STEP_ONE, 16'd0);
    wait_idle(100);
    check("re_cnt", step_count, 32'd1);
    check("re_obs", 32'(tb_obs), 32'd7);
    send(CMD_DISABLE_STEP, 16'd0);
    check("dis_adv", 32'(dsa_advance), 32'd1);
    check("dis_cap", 32'(capture_enable), 32'd0);
    send(CMD_ENABLE_STEP, 16'd0);
    check("re_en_cnt", step_count, 32'd0);
    check("re_en_cap", 32'(capture_enable), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
